// File: rtl/shape_sequencer.sv
// -----------------------------------------------------------------------------
// shape_sequencer
//
// Steps the splitter select (output_sel) through the segments of one accepted
// draw command (line: 1 segment, triangle: 3, circle: 1). Each selected
// {start, end} pair is registered and offered to the line-drawing engine over a
// valid/ready handshake. A one-cycle shape_done pulse follows the last accepted
// segment. A reserved shape type is accepted, flagged with cmd_err, and dropped.
//
// Ports
//   clk            system clock, rising edge
//   n_rst          asynchronous active-low reset
//   cmd_valid      opcode register holds a new draw command
//   shape_type     00 line, 01 triangle, 10 circle, 11 reserved
//   cmd_ready      high in IDLE only (combinational from state)
//   output_sel     splitter select; 4'hF when no segment is selected
//   locations      splitter pair: [37:19] start/center, [18:0] end/radius
//   seg_valid      registered segment available to the drawing engine
//   seg_ready      drawing engine accepts the segment
//   seg_start      registered locations[37:19]
//   seg_end        registered locations[18:0]
//   seg_is_circle  segment is a center/radius pair
//   busy           high whenever not IDLE (combinational from state)
//   shape_done     one-cycle pulse after the last segment handshake
//   cmd_err        one-cycle pulse after a reserved type is accepted
// -----------------------------------------------------------------------------
module shape_sequencer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  input  logic [1:0]  shape_type,
  output logic        cmd_ready,
  output logic [3:0]  output_sel,
  input  logic [37:0] locations,
  output logic        seg_valid,
  input  logic        seg_ready,
  output logic [18:0] seg_start,
  output logic [18:0] seg_end,
  output logic        seg_is_circle,
  output logic        busy,
  output logic        shape_done,
  output logic        cmd_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEL   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SHAPE_LINE   = 2'b00;
  localparam logic [1:0] SHAPE_TRI    = 2'b01;
  localparam logic [1:0] SHAPE_CIRCLE = 2'b10;
  localparam logic [1:0] SHAPE_RSVD   = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [1:0]  idx_q, idx_d;
  logic [18:0] seg_start_q, seg_end_q;
  logic        seg_is_circle_q;
  logic        seg_valid_q;
  logic        shape_done_q;
  logic        cmd_err_q;

  logic        seg_load;
  logic        cmd_err_d;
  logic [1:0]  last_idx;
  logic [3:0]  sel_base;

  // Segment table: first select code and last segment index per shape.
  always_comb begin
    sel_base = 4'hF;
    last_idx = 2'd0;
    case (type_q)
      SHAPE_LINE:   sel_base = 4'h0;
      SHAPE_TRI:    begin sel_base = 4'h1; last_idx = 2'd2; end
      SHAPE_CIRCLE: sel_base = 4'h4;
      default:      sel_base = 4'hF;  // reserved type never leaves IDLE
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    idx_d     = idx_q;
    seg_load  = 1'b0;
    cmd_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (shape_type == SHAPE_RSVD) begin
            cmd_err_d = 1'b1;
          end else begin
            type_d  = shape_type;
            idx_d   = 2'd0;
            state_d = ST_SEL;
          end
        end
      end
      ST_SEL: begin
        // The splitter pair for the current select is captured this edge.
        seg_load = 1'b1;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (seg_ready) begin
          if (idx_q == last_idx) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_SEL;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the segment data registers are reset too, so the engine never sees
  // stale coordinates after a reset even though seg_valid already qualifies them.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= ST_IDLE;
      type_q          <= SHAPE_LINE;
      idx_q           <= 2'd0;
      seg_start_q     <= '0;
      seg_end_q       <= '0;
      seg_is_circle_q <= 1'b0;
      seg_valid_q     <= 1'b0;
      shape_done_q    <= 1'b0;
      cmd_err_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      idx_q        <= idx_d;
      seg_valid_q  <= (state_d == ST_ISSUE);
      shape_done_q <= (state_d == ST_DONE);
      cmd_err_q    <= cmd_err_d;
      if (seg_load) begin
        seg_start_q     <= locations[37:19];
        seg_end_q       <= locations[18:0];
        seg_is_circle_q <= (type_q == SHAPE_CIRCLE);
      end
    end
  end

  // Select is held through ISSUE so the splitter pair matches the held segment.
  assign output_sel    = (state_q == ST_SEL || state_q == ST_ISSUE)
                         ? (sel_base + {2'b00, idx_q}) : 4'hF;
  assign cmd_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign seg_valid     = seg_valid_q;
  assign seg_start     = seg_start_q;
  assign seg_end       = seg_end_q;
  assign seg_is_circle = seg_is_circle_q;
  assign shape_done    = shape_done_q;
  assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_shape_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shape_sequencer
//
// Drives draw commands into shape_sequencer with a small splitter model that
// maps output_sel to {start, end} pairs taken from three corner registers.
// Expected segments are queued when a command is issued and popped on each
// seg_valid/seg_ready handshake. Cycle timing, back-pressure, reserved types
// and mid-shape reset are checked in the main flow.
// -----------------------------------------------------------------------------
module tb_shape_sequencer;

  logic        clk;
  logic        n_rst;
  logic        cmd_valid;
  logic [1:0]  shape_type;
  logic        cmd_ready;
  logic [3:0]  output_sel;
  logic [37:0] locations;
  logic        seg_valid;
  logic        seg_ready;
  logic [18:0] seg_start;
  logic [18:0] seg_end;
  logic        seg_is_circle;
  logic        busy;
  logic        shape_done;
  logic        cmd_err;

  shape_sequencer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .cmd_valid     (cmd_valid),
    .shape_type    (shape_type),
    .cmd_ready     (cmd_ready),
    .output_sel    (output_sel),
    .locations     (locations),
    .seg_valid     (seg_valid),
    .seg_ready     (seg_ready),
    .seg_start     (seg_start),
    .seg_end       (seg_end),
    .seg_is_circle (seg_is_circle),
    .busy          (busy),
    .shape_done    (shape_done),
    .cmd_err       (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Opcode register contents: corners A, B, C (line/circle use A and B).
  logic [18:0] pa, pb, pc;

  always_comb begin
    locations = '0;
    case (output_sel)
      4'h0:    locations = {pa, pb};
      4'h1:    locations = {pa, pb};
      4'h2:    locations = {pb, pc};
      4'h3:    locations = {pa, pc};
      4'h4:    locations = {pa, pb};
      default: locations = '0;
    endcase
  end

  typedef struct packed {
    logic [3:0]  sel;
    logic [18:0] st;
    logic [18:0] en;
    logic        circ;
  } seg_t;

  seg_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;
  int err_seen = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from state changes.
  logic        prev_valid = 1'b0;
  logic [18:0] prev_st, prev_en;
  logic        prev_circ;
  logic [3:0]  prev_sel;

  always @(negedge clk) begin
    if (!n_rst) begin
      prev_valid = 1'b0;
    end else begin
      if (shape_done) done_seen++;
      if (cmd_err) err_seen++;
      if (seg_valid && prev_valid) begin
        check("stall_start", seg_start, prev_st);
        check("stall_end", seg_end, prev_en);
        check("stall_circ", seg_is_circle, prev_circ);
        check("stall_sel", output_sel, prev_sel);
      end
      prev_valid = seg_valid && !seg_ready;
      prev_st    = seg_start;
      prev_en    = seg_end;
      prev_circ  = seg_is_circle;
      prev_sel   = output_sel;
      if (seg_valid && seg_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          seg_t e;
          e = sb.pop_front();
          check("seg_sel", output_sel, e.sel);
          check("seg_start", seg_start, e.st);
          check("seg_end", seg_end, e.en);
          check("seg_circ", seg_is_circle, e.circ);
        end
      end
    end
  end

  // Issues one command starting on a fresh cycle (cycle 0 = accept cycle) and
  // follows it to completion. Stalls seg_ready for stall_len ISSUE cycles on
  // segment number stall_seg; poke raises cmd_valid in the middle of the stall.
  task automatic run_cmd(input string name, input logic [1:0] t,
                         input logic [18:0] a, input logic [18:0] b, input logic [18:0] c,
                         input int stall_seg, input int stall_len,
                         input int exp_done, input bit poke);
    int hs, stalled, done_at, done0;
    logic [3:0] exp_base;
    seg_t e;
    @(posedge clk); #1;
    pa = a; pb = b; pc = c;
    case (t)
      2'b00: begin exp_base = 4'h0; e = '{4'h0, a, b, 1'b0}; sb.push_back(e); end
      2'b01: begin
        exp_base = 4'h1;
        e = '{4'h1, a, b, 1'b0}; sb.push_back(e);
        e = '{4'h2, b, c, 1'b0}; sb.push_back(e);
        e = '{4'h3, a, c, 1'b0}; sb.push_back(e);
      end
      default: begin exp_base = 4'h4; e = '{4'h4, a, b, 1'b1}; sb.push_back(e); end
    endcase
    done0 = done_seen; hs = 0; stalled = 0; done_at = -1;
    cmd_valid = 1'b1; shape_type = t; seg_ready = 1'b1;
    @(negedge clk);
    check({name, "_ready_c0"}, cmd_ready, 1);
    for (int cy = 1; cy <= 40; cy++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (seg_valid && hs == stall_seg && stalled < stall_len) begin
        seg_ready = 1'b0;
        stalled++;
        if (poke && stalled == 2) begin
          cmd_valid  = 1'b1;
          shape_type = 2'b00;
        end
      end else begin
        seg_ready = 1'b1;
      end
      @(negedge clk);
      if (cy == 1) check({name, "_sel_c1"}, output_sel, exp_base);
      if (seg_valid && seg_ready) hs++;
      if (shape_done && done_at < 0) done_at = cy;
      if (done_at >= 0 && cy == done_at + 1) begin
        check({name, "_ready_back"}, cmd_ready, 1);
        check({name, "_busy_back"}, busy, 0);
        break;
      end
      check({name, "_busy"}, busy, 1);
    end
    check({name, "_done_cycle"}, done_at, exp_done);
    check({name, "_done_count"}, done_seen - done0, 1);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    int e0, vcount, d0;
    bit reached;
    n_rst = 1'b0; cmd_valid = 1'b0; shape_type = 2'b00; seg_ready = 1'b1;
    pa = '0; pb = '0; pc = '0;
    #3;
    check("rst_seg_valid", seg_valid, 0);
    check("rst_seg_start", seg_start, 0);
    check("rst_seg_end", seg_end, 0);
    check("rst_seg_circ", seg_is_circle, 0);
    check("rst_done", shape_done, 0);
    check("rst_err", cmd_err, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_sel", output_sel, 4'hF);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    run_cmd("line", 2'b00, 19'h0A0C8, 19'h12C64, 19'h0, -1, 0, 3, 1'b0);
    run_cmd("tri", 2'b01, 19'd1, 19'd2, 19'd3, -1, 0, 7, 1'b0);
    run_cmd("circle", 2'b10, 19'h05050, 19'h00020, 19'h0, -1, 0, 3, 1'b0);
    run_cmd("tri_stall", 2'b01, 19'h7FFFF, 19'h00000, 19'h2AAAA, 1, 5, 12, 1'b1);

    // Reserved type: single cmd_err pulse, no segment, stays idle.
    @(posedge clk); #1;
    e0 = err_seen; vcount = 0;
    cmd_valid = 1'b1; shape_type = 2'b11;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rsvd_err", cmd_err, 1);
    check("rsvd_busy", busy, 0);
    check("rsvd_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (seg_valid) vcount++;
    end
    check("rsvd_err_count", err_seen - e0, 1);
    check("rsvd_no_valid", vcount, 0);
    run_cmd("after_rsvd", 2'b00, 19'h00111, 19'h00222, 19'h0, -1, 0, 3, 1'b0);

    // Reset during ISSUE of the second triangle segment.
    @(posedge clk); #1;
    pa = 19'h00010; pb = 19'h00020; pc = 19'h00030;
    sb.push_back('{4'h1, 19'h00010, 19'h00020, 1'b0});
    sb.push_back('{4'h2, 19'h00020, 19'h00030, 1'b0});
    sb.push_back('{4'h3, 19'h00010, 19'h00030, 1'b0});
    cmd_valid = 1'b1; shape_type = 2'b01; seg_ready = 1'b1;
    reached = 1'b0;
    begin : find_issue2
      int hs;
      hs = 0;
      for (int cy = 1; cy <= 20; cy++) begin
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (seg_valid && hs == 1) begin
          reached = 1'b1;
          seg_ready = 1'b0;
          break;
        end
        seg_ready = 1'b1;
        @(negedge clk);
        if (seg_valid && seg_ready) hs++;
      end
    end
    check("rstmid_reached", reached, 1);
    d0 = done_seen;
    #2 n_rst = 1'b0;
    #1;
    check("rstmid_valid", seg_valid, 0);
    check("rstmid_start", seg_start, 0);
    check("rstmid_end", seg_end, 0);
    check("rstmid_sel", output_sel, 4'hF);
    check("rstmid_ready", cmd_ready, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_sb_left", sb.size(), 2);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    seg_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_no_done", done_seen - d0, 0);
    run_cmd("after_rst", 2'b00, 19'h0A0C8, 19'h12C64, 19'h0, -1, 0, 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
